// File: rtl/decryption_controller_if.sv
// Handshake and datapath-control bundle between the AES wrapper/datapath and
// the inverse-cipher sequencer. The master modport is the sequencer's view.
interface decryption_controller_if #(
  parameter int CNT_W = 4
);
  logic             decrypt_enable;
  logic             key_ready;
  logic             abort;
  logic [127:0]     state_in;
  logic             load_state;
  logic [CNT_W-1:0] round_key_index;
  logic             inv_shift_rows_enable;
  logic             inv_sub_bytes_enable;
  logic             add_round_key_enable;
  logic             inv_mix_cols_enable;
  logic             busy;
  logic             plain_valid;
  logic [127:0]     plainOut;

  modport master (
    input  decrypt_enable, key_ready, abort, state_in,
    output load_state, round_key_index, inv_shift_rows_enable,
           inv_sub_bytes_enable, add_round_key_enable, inv_mix_cols_enable,
           busy, plain_valid, plainOut
  );

  modport slave (
    output decrypt_enable, key_ready, abort, state_in,
    input  load_state, round_key_index, inv_shift_rows_enable,
           inv_sub_bytes_enable, add_round_key_enable, inv_mix_cols_enable,
           busy, plain_valid, plainOut
  );
endinterface

// File: rtl/decryption_controller.sv
// AES-128 InvCipher sequencer: walks an external datapath through the round
// operations with round keys NUM_ROUNDS..0, then captures the plaintext.
module decryption_controller #(
  parameter int NUM_ROUNDS = 10,
  parameter int CNT_W      = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  decryption_controller_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, WAIT_KEY, LOAD, INIT_ARK, INV_SR_SB, INV_ARK, INV_MIX, DONE
  } state_e;

  localparam logic [CNT_W-1:0] FIRST_KEY = CNT_W'(NUM_ROUNDS);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_q, ark_q, sr_sb_q, mix_q, busy_q, valid_q;
  logic [127:0]     plain_q;
  logic             finish;

  assign finish = (state_q == DONE) && !bus.abort;

  always_comb begin
    // NOTE: defaults first so every path assigns every signal; no latches.
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE:     if (bus.decrypt_enable) state_d = WAIT_KEY;
        WAIT_KEY: if (bus.key_ready) begin
                    state_d = LOAD;
                    cnt_d   = FIRST_KEY;
                  end
        LOAD:     state_d = INIT_ARK;
        INIT_ARK: begin
                    state_d = INV_SR_SB;
                    if (cnt_q != '0) cnt_d = cnt_q - ONE;
                  end
        INV_SR_SB: state_d = INV_ARK;
        INV_ARK:  state_d = (cnt_q != '0) ? INV_MIX : DONE;
        INV_MIX:  begin
                    state_d = INV_SR_SB;
                    if (cnt_q != '0) cnt_d = cnt_q - ONE;
                  end
        DONE:     state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // NOTE: output flops decode state_d, so they always match state_q's decode
  // while driving the datapath glitch-free straight from registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      ark_q   <= 1'b0;
      sr_sb_q <= 1'b0;
      mix_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      plain_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_q  <= (state_d == LOAD);
      ark_q   <= (state_d == INIT_ARK) || (state_d == INV_ARK);
      sr_sb_q <= (state_d == INV_SR_SB);
      mix_q   <= (state_d == INV_MIX);
      busy_q  <= (state_d != IDLE);
      valid_q <= finish;
      if (finish) plain_q <= bus.state_in;
    end
  end

  assign bus.load_state            = load_q;
  assign bus.round_key_index       = cnt_q;
  assign bus.add_round_key_enable  = ark_q;
  assign bus.inv_shift_rows_enable = sr_sb_q;
  assign bus.inv_sub_bytes_enable  = sr_sb_q;
  assign bus.inv_mix_cols_enable   = mix_q;
  assign bus.busy                  = busy_q;
  assign bus.plain_valid           = valid_q;
  assign bus.plainOut              = plain_q;

endmodule

// File: doc/decryption_controller.md
Name: decryption_controller

Overview:
- FSM that sequences the AES-128 inverse cipher (FIPS-197 InvCipher) over an external datapath. It is the decrypt-side counterpart of the encryption controller.
- It drives the datapath's InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns enables, and selects round keys 10 down to 0 from the key schedule.
- It captures the final datapath state as plaintext and raises a one-cycle valid pulse.
- It sits between the top-level AES wrapper and the shared key-schedule/datapath blocks.

Parameters:
- NUM_ROUNDS, 10, number of AES rounds; the round counter loads this value.
- CNT_W, 4, round counter and round_key_index width; must satisfy 2^CNT_W > NUM_ROUNDS.

Ports:
- clk  in  1  clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- decrypt_enable  in  1  start request; sampled only in IDLE.
- key_ready  in  1  key schedule has all round keys expanded; checked only in WAIT_KEY.
- abort  in  1  synchronous abort; highest priority after reset.
- state_in  in  128  current datapath state register contents.
- load_state  out  1  datapath loads the ciphertext into its state register.
- round_key_index  out  CNT_W  index of the round key applied by AddRoundKey.
- inv_shift_rows_enable  out  1  datapath enable.
- inv_sub_bytes_enable  out  1  datapath enable.
- add_round_key_enable  out  1  datapath enable.
- inv_mix_cols_enable  out  1  datapath enable.
- busy  out  1  high whenever state != IDLE.
- plain_valid  out  1  registered one-cycle pulse; plainOut is new.
- plainOut  out  128  registered plaintext; held until the next completion.

Behaviour:
- Reset (n_rst=0, async): state=IDLE, round_cnt=0, plainOut=0, plain_valid=0.
  - All enables, load_state and busy read 0.
- States: IDLE, WAIT_KEY, LOAD, INIT_ARK, INV_SR_SB, INV_ARK, INV_MIX, DONE.
  - Encoding is free; any unreachable encoding returns to IDLE on the next edge.
- Transitions:
  - IDLE -> WAIT_KEY when decrypt_enable=1; otherwise stay.
  - WAIT_KEY -> LOAD when key_ready=1; otherwise stay. round_cnt<=NUM_ROUNDS on this edge.
  - LOAD -> INIT_ARK.
  - INIT_ARK -> INV_SR_SB. round_cnt decrements on this edge.
  - INV_SR_SB -> INV_ARK.
  - INV_ARK -> INV_MIX if round_cnt!=0; INV_ARK -> DONE if round_cnt==0.
  - INV_MIX -> INV_SR_SB. round_cnt decrements on this edge.
  - DONE -> IDLE. plainOut<=state_in and plain_valid<=1 on this edge.
- plain_valid is cleared on every other edge, so it is exactly one cycle wide.
- Moore outputs, decoded from state only:
  - load_state = LOAD.
  - add_round_key_enable = INIT_ARK or INV_ARK.
  - inv_shift_rows_enable = inv_sub_bytes_enable = INV_SR_SB.
  - inv_mix_cols_enable = INV_MIX.
  - round_key_index = round_cnt in every state.
- Round order: INIT_ARK uses key 10. Rounds 9..1 each run SR_SB, ARK(r), MIX. The final round runs SR_SB, ARK(0) with no MIX.
  - AddRoundKey indices over one operation are exactly 10,9,...,1,0.
  - InvMixColumns fires exactly 9 times.
- Datapath contract: the datapath updates its state register on the edge ending each enabled cycle. state_in in DONE is the plaintext.
- Latency, with decrypt_enable high in cycle 0 and key_ready already high:
  - WAIT_KEY occupies cycle 1 and DONE occupies cycle 33.
  - plain_valid=1 and busy=0 in cycle 34.
  - Each cycle key_ready is low adds one cycle.
- Boundaries:
  - decrypt_enable while busy: ignored; no queuing.
  - decrypt_enable held high: a new operation starts the cycle after plain_valid.
  - key_ready deasserting after WAIT_KEY: ignored.
  - abort=1 in any state: next state IDLE, round_cnt<=0, plain_valid<=0, plainOut unchanged.
  - abort and decrypt_enable together in IDLE: abort wins; stay in IDLE.
  - Reset mid-operation: immediate return to reset values; no plain_valid.
  - round_cnt never wraps; decrements only occur while round_cnt>=1.

Test Plan:
- FIPS-197 C.1 vector, with a bench datapath model and key ready. Ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, key 000102...0f.
  -> plainOut=00112233445566778899aabbccddeeff; plain_valid high in cycle 34 only; busy high cycles 1–33.
- Enable sequencing trace for the same run:
  - round_key_index sampled at add_round_key_enable = 10,9,...,0.
  - inv_mix_cols_enable count = 9.
  - The last SR_SB is followed by ARK(0) with no MIX.
- Key wait: key_ready low for 5 cycles after the start.
  -> FSM holds WAIT_KEY for 5 extra cycles; plain_valid in cycle 39; same plaintext.
- Abort in INV_MIX with round_cnt=5.
  -> IDLE the next cycle; busy=0; plain_valid never pulses; plainOut keeps the previous value.
- n_rst pulsed low during INV_SR_SB.
  -> all outputs 0 immediately; a new decrypt_enable afterwards completes normally in 34 cycles.
- decrypt_enable pulsed again in cycle 10, then held high across completion.
  -> the cycle-10 pulse is ignored; a second operation enters WAIT_KEY in cycle 35; two separate single-cycle plain_valid pulses.
